pipe_hazard_unit: RTL
=====================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding unit for the ID stage of the pipelined CPU.
- The previous decoder compared rs/rt against fixed EXE/MEM destination inputs. This block keeps its own destination scoreboard, a shift register of in-flight writers spanning DEPTH post-ID stages.
- It generates per-operand forwarding selects, a load-use stall and a saturating stall counter.
- It sits beside the instruction decoder. Forward selects drive the ID operand muxes; nostall gates the PC, IF/ID writes and the decoder's wreg/wmem.

Parameters:
- AW, 5, register-number width (2**AW architectural registers; register 0 is hardwired zero).
- DEPTH, 3, post-ID stages tracked (entry 0 = EXE, 1 = MEM, 2 = WB, ...). Must be >= 1.
- LOAD_LAT, 1, first entry index at which load data exists on that stage's result bus. Must be < DEPTH.
- CW, 16, stall counter width.
- FW, clog2(DEPTH+1), forward-select width (derived; not overridable).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_rs  in  AW  source register A.
- id_rt  in  AW  source register B.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wreg  in  1  instruction writes a register (ungated by stall).
- id_rn  in  AW  destination register (after regrt/jal selection).
- id_m2reg  in  1  instruction is a load.
- flush  in  1  squash the ID instruction (taken branch or jump cancel).
- fwda  out  FW  operand A select: 0 = register file, k+1 = result bus of entry k.
- fwdb  out  FW  operand B select, same encoding.
- nostall  out  1  0 = hold PC and IF/ID, insert bubble.
- stall_cnt  out  CW  saturating count of stall cycles.

Behaviour:
- Scoreboard: DEPTH entries, each {v, rn[AW-1:0], ld}. All entries shift one place every clock; the stages after ID never stall. Entry DEPTH-1 is discarded.
- Entry 0 load: if nostall & ~flush, load {id_valid & id_wreg & (id_rn != 0), id_rn, id_m2reg}. Otherwise load v = 0 (bubble).
- Match per operand (rs shown; rt identical):
  - match_k = v_k & (rn_k == id_rs) & id_use_rs & id_valid.
  - Select the lowest k with match_k set (the youngest writer wins).
  - No match gives fwda = 0.
  - id_rs == 0 never matches, because entries never hold rn = 0.
- Hazard for the selected k: ld_k & (k < LOAD_LAT). Otherwise fwda = k+1.
- nostall = ~(hazard_a | hazard_b). Under a hazard, fwda/fwdb are don't-care; the bench does not check them.
- Forwards and nostall are combinational from the entries and ID inputs, with zero latency. Only the scoreboard and stall_cnt are registered.
- stall_cnt increments on each clock with nostall = 0. It holds at all-ones (no wrap).
- flush with a hazard present: the entry 0 bubble is still inserted, nostall is still driven from the hazard terms, and stall_cnt still counts.
- Reset:
  - Clears all v, rn and ld, and sets stall_cnt = 0.
  - Consequently fwda = fwdb = 0 and nostall = 1 in the cycle after reset.
  - Reset asserted mid-operation discards all in-flight entries, with no forwarding from pre-reset writers.
- Generic stall length: a load-use stall lasts exactly LOAD_LAT - k cycles, where k is the entry holding the load. The bubble pushes advance the load until k = LOAD_LAT.

Test Plan (DEPTH=3, LOAD_LAT=1):
- Reset for 2 cycles, then release -> fwda=0, fwdb=0, nostall=1, stall_cnt=0.
- Push addi rn=5, then present id_rs=5, use_rs=1 for three cycles (inserting bubbles) -> fwda=1, then 2, then 3; fourth cycle fwda=0.
- Push lw rn=8, next ID reads rt=8 -> nostall=0 for one cycle and stall_cnt=1. The following cycle gives nostall=1, fwdb=2.
- Entry 0 ALU rn=3 and entry 1 load rn=3, ID reads rs=3 -> fwda=1, nostall=1 (youngest wins). Swap (entry 0 load) -> nostall=0.
- Push id_wreg=1, id_rn=0, then read rs=0 -> fwda=0. Push rn=7 with flush=1, then read rs=7 -> fwda=0.
- Force 2**CW+3 stall cycles with CW=4 -> stall_cnt saturates at 15. Assert reset mid-stall -> stall_cnt=0, nostall=1 the next cycle.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   ID-stage hazard and forwarding unit. A private scoreboard follows every
//   register writer through the DEPTH stages after ID (entry 0 = EXE,
//   1 = MEM, 2 = WB, ...). It produces per-operand forward selects, a
//   load-use stall and a saturating count of stall cycles.
//
// Parameters
//   AW        register-number width (register 0 is hardwired zero)
//   DEPTH     post-ID stages tracked (>= 1)
//   LOAD_LAT  first entry index whose result bus carries load data (< DEPTH)
//   CW        stall counter width
//   FW        forward-select width, derived from DEPTH
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   id_valid              ID holds a real instruction
//   id_rs / id_rt         source register numbers
//   id_use_rs / id_use_rt instruction reads that source
//   id_wreg, id_rn        instruction writes register id_rn
//   id_m2reg              instruction is a load
//   flush                 squash the ID instruction
//   fwda / fwdb           0 = register file, k+1 = result bus of entry k
//   nostall               0 = hold PC and IF/ID, insert a bubble
//   stall_cnt             saturating count of stall cycles
module pipe_hazard_unit #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 16,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wreg,
  input  logic [AW-1:0] id_rn,
  input  logic          id_m2reg,
  input  logic          flush,
  output logic [FW-1:0] fwda,
  output logic [FW-1:0] fwdb,
  output logic          nostall,
  output logic [CW-1:0] stall_cnt
);

  // Scoreboard entries: valid, destination register, writer is a load.
  logic          v_q  [DEPTH];
  logic [AW-1:0] rn_q [DEPTH];
  logic          ld_q [DEPTH];

  logic [CW-1:0] stall_cnt_q;
  logic [CW-1:0] stall_cnt_d;

  logic hazard_a;
  logic hazard_b;
  logic push_v;

  // Scan from the oldest entry to the youngest so that the youngest matching
  // writer overwrites any older match. Entries never hold rn = 0, so a read
  // of register 0 can never match.
  always_comb begin
    fwda     = '0;
    fwdb     = '0;
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v_q[k] && (rn_q[k] == id_rs) && id_use_rs && id_valid) begin
        fwda     = FW'(k + 1);
        hazard_a = ld_q[k] && (k < LOAD_LAT);
      end
      if (v_q[k] && (rn_q[k] == id_rt) && id_use_rt && id_valid) begin
        fwdb     = FW'(k + 1);
        hazard_b = ld_q[k] && (k < LOAD_LAT);
      end
    end
  end

  assign nostall = ~(hazard_a | hazard_b);

  // A stalled or flushed instruction enters the pipe as a bubble.
  assign push_v = nostall & ~flush & id_valid & id_wreg & (id_rn != '0);

  assign stall_cnt_d = (!nostall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1
                                                         : stall_cnt_q;

  // The stages after ID never stall, so every entry shifts each clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]  <= 1'b0;
        rn_q[k] <= '0;
        ld_q[k] <= 1'b0;
      end
      stall_cnt_q <= '0;
    end else begin
      v_q[0]  <= push_v;
      rn_q[0] <= push_v ? id_rn : '0;
      ld_q[0] <= push_v & id_m2reg;
      for (int k = 1; k < DEPTH; k++) begin
        v_q[k]  <= v_q[k-1];
        rn_q[k] <= rn_q[k-1];
        ld_q[k] <= ld_q[k-1];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
